lfsr_range_rng: RTL

Parametrised pseudo-random source for the game-control layer. It runs a Galois LFSR of configurable width and polynomial, supports a runtime reseed, and serves range-limited draws over a req/valid handshake. Each draw returns a uniform value in [min_val, max_val], using rejection sampling with a bounded retry count. Consumers are duck spawn position, direction and timing logic, which need bounded values rather than raw LFSR bits.

---
 rtl/lfsr_range_rng.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lfsr_range_rng.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_range_rng
// Purpose  : Galois-LFSR pseudo-random source with runtime reseed and
//            range-limited draws. A request latches [min,max] (swapped if
//            reversed), and the block draws masked LFSR bits until one lands
//            inside the span. If MAX_TRY draws are all rejected, a
//            folded-back fallback value is used instead.
// Ports    : clk_i          system clock, rising edge
//            rst_ni         asynchronous active-low reset
//            seed_load_i    load seed_in_i into the LFSR at the next edge
//            seed_in_i      reseed value (zero maps to SEED)
//            req_i          request one ranged value, sampled only in IDLE
//            min_val_i      lower bound, inclusive
//            max_val_i      upper bound, inclusive
//            busy_o         request in progress, req_i ignored
//            valid_o        one-cycle pulse, value_o is fresh
//            value_o        result, held until the next valid
//            lfsr_state_o   raw LFSR register
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_range_rng #(
    parameter int                 WIDTH   = 16,
    parameter logic [WIDTH-1:0]   TAPS    = 16'hB400,
    parameter logic [WIDTH-1:0]   SEED    = 16'hACE1,
    parameter int                 OUT_W   = 10,
    parameter int                 MAX_TRY = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                seed_load_i,
    input  logic [WIDTH-1:0]    seed_in_i,
    input  logic                req_i,
    input  logic [OUT_W-1:0]    min_val_i,
    input  logic [OUT_W-1:0]    max_val_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic [OUT_W-1:0]    value_o,
    output logic [WIDTH-1:0]    lfsr_state_o
);

    localparam int TRY_W = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SETUP = 2'd1;
    localparam logic [1:0] c_ST_DRAW  = 2'd2;

    localparam logic [TRY_W-1:0] c_LAST_TRY = TRY_W'(MAX_TRY - 1);
    localparam logic [TRY_W-1:0] c_TRY_ONE  = TRY_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   lfsr_q,  lfsr_d;
    logic [1:0]         state_q, state_d;
    logic [OUT_W-1:0]   lo_q,    lo_d;
    logic [OUT_W-1:0]   hi_q,    hi_d;
    logic [OUT_W:0]     span_q,  span_d;
    logic [OUT_W-1:0]   mask_q,  mask_d;
    logic [TRY_W-1:0]   try_q,   try_d;
    logic               busy_q,  busy_d;
    logic               valid_q, valid_d;
    logic [OUT_W-1:0]   value_q, value_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   w_lfsr_step;
    logic [OUT_W-1:0]   w_diff;
    logic [OUT_W:0]     w_span;
    logic [OUT_W-1:0]   w_mask;
    logic [OUT_W-1:0]   w_cand;
    logic               w_accept;
    logic [OUT_W-1:0]   w_fold;

    // Galois step: shift right, XOR taps in when the dropped bit was 1.
    assign w_lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

    // span = hi - lo + 1 needs one extra bit so the full range does not wrap.
    assign w_diff = hi_q - lo_q;
    assign w_span = {1'b0, w_diff} + {{OUT_W{1'b0}}, 1'b1};

    // Smallest all-ones mask covering span-1 (= hi-lo): smear the leading
    // one downward. This equals 2^k-1 with the smallest k such that 2^k >= span.
    always_comb begin
        w_mask = w_diff;
        for (int i = OUT_W - 2; i >= 0; i--) begin
            w_mask[i] = w_mask[i] | w_mask[i+1];
        end
    end

    assign w_cand   = lfsr_q[OUT_W-1:0] & mask_q;
    assign w_accept = ({1'b0, w_cand} < span_q);

    // Fallback only runs when cand >= span. In that case span <= mask < 2^OUT_W,
    // so the low OUT_W bits of span are exact. Because mask < 2*span, the
    // folded value is < span.
    assign w_fold = w_cand - span_q[OUT_W-1:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        lfsr_d = seed_load_i ? ((seed_in_i == '0) ? SEED : seed_in_i) : w_lfsr_step;
    end

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        span_d  = span_q;
        mask_d  = mask_q;
        try_d   = try_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        value_d = value_q;

        case (state_q)
            c_ST_IDLE: begin
                if (req_i) begin
                    if (min_val_i <= max_val_i) begin
                        lo_d = min_val_i;
                        hi_d = max_val_i;
                    end else begin
                        lo_d = max_val_i;
                        hi_d = min_val_i;
                    end
                    busy_d  = 1'b1;
                    state_d = c_ST_SETUP;
                end
            end

            c_ST_SETUP: begin
                span_d  = w_span;
                mask_d  = w_mask;
                try_d   = '0;
                state_d = c_ST_DRAW;
            end

            c_ST_DRAW: begin
                if (w_accept) begin
                    value_d = lo_q + w_cand;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = c_ST_IDLE;
                end else if (try_q == c_LAST_TRY) begin
                    value_d = lo_q + w_fold;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = c_ST_IDLE;
                end else begin
                    try_d = try_q + c_TRY_ONE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q  <= SEED;
            state_q <= c_ST_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            span_q  <= '0;
            mask_q  <= '0;
            try_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            value_q <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            span_q  <= span_d;
            mask_q  <= mask_d;
            try_q   <= try_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            value_q <= value_d;
        end
    end

    assign busy_o       = busy_q;
    assign valid_o      = valid_q;
    assign value_o      = value_q;
    assign lfsr_state_o = lfsr_q;

endmodule
`default_nettype wire
